instr_imm_encoder: RTL and testbench

INSTR_IMM_ENCODER -- requirements
Module: instr_imm_encoder

---
 rtl/instr_imm_encoder_pkg.sv | 58 +++++
 rtl/instr_imm_encoder_imm_pack.sv | 57 +++++
 rtl/instr_imm_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_imm_encoder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: major opcodes, instruction formats,
// legal immediate ranges per format and the controller state encoding.
package instr_imm_encoder_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EMIT  = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    localparam logic signed [63:0] IMM_I_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM_I_MAX =  64'sd2047;
    localparam logic signed [63:0] IMM_S_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM_S_MAX =  64'sd2047;
    localparam logic signed [63:0] IMM_B_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM_B_MAX =  64'sd4094;
    localparam logic signed [63:0] IMM_J_MIN = -64'sd1048576;
    localparam logic signed [63:0] IMM_J_MAX =  64'sd1048574;
    localparam logic signed [63:0] IMM_U_MIN = -64'sd2147483648;
    localparam logic signed [63:0] IMM_U_MAX =  64'sd2147483647;

    function automatic fmt_e fmt_of(input logic [4:0] op);
        fmt_e f;
        case (op)
            OP_LOAD, OP_OPIMM: f = FMT_I;
            OP_STORE:          f = FMT_S;
            OP_BRANCH:         f = FMT_B;
            OP_LUI:            f = FMT_U;
            OP_JAL:            f = FMT_J;
            default:           f = FMT_NONE;
        endcase
        return f;
    endfunction

    function automatic logic in_range(input logic signed [63:0] v,
                                      input logic signed [63:0] lo,
                                      input logic signed [63:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_imm_encoder_imm_pack.sv
// Combinational format decode, immediate range check and bit scattering into a
// 32-bit instruction word.
module imm_pack
    import instr_imm_encoder_pkg::*;
(
    input  logic [4:0]  i_opcode,
    input  logic [63:0] i_imm,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    output logic        o_ok,
    output logic [31:0] o_instr
);

    logic signed [63:0] w_imm;
    fmt_e               w_fmt;
    logic [6:0]         w_major;

    assign w_imm   = $signed(i_imm);
    assign w_fmt   = fmt_of(i_opcode);
    assign w_major = {i_opcode, 2'b11};

    // Branch and jump offsets are halfword multiples, so bit 0 must be clear.
    always_comb begin
        o_ok    = 1'b0;
        o_instr = {25'd0, w_major};
        case (w_fmt)
            FMT_I: begin
                o_ok    = in_range(w_imm, IMM_I_MIN, IMM_I_MAX);
                o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, w_major};
            end
            FMT_S: begin
                o_ok    = in_range(w_imm, IMM_S_MIN, IMM_S_MAX);
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], w_major};
            end
            FMT_B: begin
                o_ok    = in_range(w_imm, IMM_B_MIN, IMM_B_MAX) && !i_imm[0];
                o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], w_major};
            end
            FMT_U: begin
                o_ok    = in_range(w_imm, IMM_U_MIN, IMM_U_MAX) && (i_imm[11:0] == 12'd0);
                o_instr = {i_imm[31:12], i_rd, w_major};
            end
            FMT_J: begin
                o_ok    = in_range(w_imm, IMM_J_MIN, IMM_J_MAX) && !i_imm[0];
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_major};
            end
            default: begin
                o_ok    = 1'b0;
                o_instr = {25'd0, w_major};
            end
        endcase
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// Immediate encoder: accepts one request, checks it for a cycle, then offers the
// packed word with an incrementing word address until the 256-entry window fills.
module instr_imm_encoder
    import instr_imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  OpCode,
    input  logic [63:0] Imm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Instr,
    output logic [11:0] InstructionP1,
    output logic [4:0]  InstructionP2,
    output logic [7:0]  wr_addr,
    output logic        full,
    input  logic        clear,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and an offered word holds until taken.

    state_e      r_state;
    logic [4:0]  r_opcode;
    logic [63:0] r_imm;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;
    logic [31:0] r_instr;
    logic [7:0]  r_addr;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic        w_ok;
    logic [31:0] w_instr;
    logic        w_accept;
    logic        w_xfer;
    logic        w_check;

    imm_pack u_imm_pack (
        .i_opcode (r_opcode),
        .i_imm    (r_imm),
        .i_rd     (r_rd),
        .i_rs1    (r_rs1),
        .i_rs2    (r_rs2),
        .i_funct3 (r_funct3),
        .o_ok     (w_ok),
        .o_instr  (w_instr)
    );

    assign w_accept = (r_state == ST_IDLE)  && in_valid  && !clear;
    assign w_xfer   = (r_state == ST_EMIT)  && out_ready && !clear;
    assign w_check  = (r_state == ST_CHECK) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (in_valid) r_state <= ST_CHECK;
                ST_CHECK: r_state <= w_ok ? ST_EMIT : ST_IDLE;
                ST_EMIT: begin
                    if (out_ready) r_state <= (r_addr == 8'hFF) ? ST_FULL : ST_IDLE;
                end
                ST_FULL:  r_state <= ST_FULL;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= 5'd0;
            r_imm    <= 64'd0;
            r_rd     <= 5'd0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
            r_funct3 <= 3'd0;
        end else if (w_accept) begin
            r_opcode <= OpCode;
            r_imm    <= Imm;
            r_rd     <= rd;
            r_rs1    <= rs1;
            r_rs2    <= rs2;
            r_funct3 <= funct3;
        end
    end

    // The word register only loads on a passing check, so it is frozen during EMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= 32'd0;
        end else if (w_check && w_ok) begin
            r_instr <= w_instr;
        end
    end

    // The address saturates at 255; the FULL state records that the last slot was used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= 8'd0;
        end else if (clear) begin
            r_addr <= 8'd0;
        end else if (w_xfer && (r_addr != 8'hFF)) begin
            r_addr <= r_addr + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (clear) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (w_check && !w_ok) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign in_ready      = (r_state == ST_IDLE) && !clear;
    assign out_valid     = (r_state == ST_EMIT) && !clear;
    assign full          = (r_state == ST_FULL);
    assign Instr         = r_instr;
    assign InstructionP1 = r_instr[31:20];
    assign InstructionP2 = r_instr[11:7];
    assign wr_addr       = r_addr;
    assign err           = r_err;
    assign err_count     = r_err_cnt;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed bench for instr_imm_encoder with a transaction-level reference model
// checked every cycle, plus hand-computed literal words.
module tb_instr_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  OpCode;
    logic [63:0] Imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Instr;
    logic [11:0] InstructionP1;
    logic [4:0]  InstructionP2;
    logic [7:0]  wr_addr;
    logic        full;
    logic        clear;
    logic        err;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    instr_imm_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .OpCode        (OpCode),
        .Imm           (Imm),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .funct3        (funct3),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Instr         (Instr),
        .InstructionP1 (InstructionP1),
        .InstructionP2 (InstructionP2),
        .wr_addr       (wr_addr),
        .full          (full),
        .clear         (clear),
        .err           (err),
        .err_count     (err_count),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoder written straight from the format tables.
    function automatic void model_enc(input logic [4:0] op, input logic signed [63:0] imm,
                                      input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [2:0] f,
                                      output logic ok, output logic [31:0] w);
        logic [6:0] low;
        low = {op, 2'b11};
        ok  = 1'b0;
        w   = 32'd0;
        case (op)
            5'b00000, 5'b00100: begin
                ok = (imm >= -64'sd2048) && (imm <= 64'sd2047);
                w  = {imm[11:0], s1, f, d, low};
            end
            5'b01000: begin
                ok = (imm >= -64'sd2048) && (imm <= 64'sd2047);
                w  = {imm[11:5], s2, s1, f, imm[4:0], low};
            end
            5'b11000: begin
                ok = (imm >= -64'sd4096) && (imm <= 64'sd4094) && (imm[0] == 1'b0);
                w  = {imm[12], imm[10:5], s2, s1, f, imm[4:1], imm[11], low};
            end
            5'b01101: begin
                ok = (imm >= -64'sd2147483648) && (imm <= 64'sd2147483647) && (imm[11:0] == 12'd0);
                w  = {imm[31:12], d, low};
            end
            5'b11011: begin
                ok = (imm >= -64'sd1048576) && (imm <= 64'sd1048574) && (imm[0] == 1'b0);
                w  = {imm[20], imm[10:1], imm[11], imm[19:12], d, low};
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // ImmGen: recover the sign-extended immediate from an encoded word.
    function automatic logic [63:0] immgen(input logic [31:0] w);
        logic [63:0] r;
        case (w[6:2])
            5'b00000, 5'b00100: r = {{52{w[31]}}, w[31:20]};
            5'b01000:           r = {{52{w[31]}}, w[31:25], w[11:7]};
            5'b11000:           r = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            5'b01101:           r = {{32{w[31]}}, w[31:12], 12'd0};
            5'b11011:           r = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:            r = 64'd0;
        endcase
        return r;
    endfunction

    // Transaction model: which phase the current request is in, and the bookkeeping.
    logic        m_chk, m_chk_ok, m_pend, m_err, m_full;
    logic [31:0] m_chk_w, m_word;
    logic [63:0] m_chk_imm, m_imm;
    logic [7:0]  m_addr, m_cnt;
    logic        exp_ready, t_ok;
    logic [31:0] t_w;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_full", full, 0);
            chk("rst_err", err, 0);
            chk("rst_err_count", err_count, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_instr", Instr, 0);
            chk("rst_p1", InstructionP1, 0);
            chk("rst_p2", InstructionP2, 0);
            m_chk = 0; m_chk_ok = 0; m_pend = 0; m_err = 0; m_full = 0;
            m_chk_w = 0; m_word = 0; m_chk_imm = 0; m_imm = 0; m_addr = 0; m_cnt = 0;
        end else begin
            exp_ready = !m_full && !m_chk && !m_pend && !clear;
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, m_pend && !clear);
            chk("wr_addr", wr_addr, m_addr);
            chk("full", full, m_full);
            chk("err", err, m_err);
            chk("err_count", err_count, m_cnt);
            if (m_pend) begin
                chk("instr", Instr, m_word);
                chk("p1", InstructionP1, m_word[31:20]);
                chk("p2", InstructionP2, m_word[11:7]);
                chk("immgen_roundtrip", immgen(Instr), m_imm);
            end
            if (clear) begin
                m_addr = 0; m_err = 0; m_cnt = 0; m_full = 0; m_pend = 0; m_chk = 0;
            end else if (m_chk) begin
                m_chk = 0;
                if (m_chk_ok) begin
                    m_pend = 1; m_word = m_chk_w; m_imm = m_chk_imm;
                end else begin
                    m_err = 1;
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end
            end else if (m_pend && out_ready) begin
                m_pend = 0;
                if (m_addr == 8'd255) m_full = 1;
                else m_addr = m_addr + 8'd1;
            end else if (exp_ready && in_valid) begin
                model_enc(OpCode, Imm, rd, rs1, rs2, funct3, t_ok, t_w);
                m_chk = 1; m_chk_ok = t_ok; m_chk_w = t_w; m_chk_imm = Imm;
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [63:0] imm, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f);
        bit got;
        got = 0;
        @(posedge clk); #1;
        OpCode = op; Imm = imm; rd = d; rs1 = s1; rs2 = s2; funct3 = f; in_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", got, 1);
    endtask

    task automatic wait_out(output int lat);
        bit seen;
        seen = 0;
        lat = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                lat = cyc - acc_cyc;
            end
        end
        chk("out_valid_seen", seen, 1);
    endtask

    task automatic expect_reject();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reject_no_out_valid", out_valid, 0);
        end
    endtask

    int          lat;
    logic [31:0] w0;
    logic [7:0]  a0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
        OpCode = '0; Imm = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_wr_addr", wr_addr, 0);

        // Load with Imm -3: latency, upper field and address pinned by hand.
        send(5'b00000, -64'sd3, 5'd0, 5'd1, 5'd0, 3'd0);
        wait_out(lat);
        chk("a_latency", lat, 2);
        chk("a_p1", InstructionP1, 12'b111111111101);
        chk("a_wr_addr", wr_addr, 0);
        chk("a_instr", Instr, 32'hFFD08003);

        // Store with Imm -3 and ImmGen round trip.
        send(5'b01000, -64'sd3, 5'd0, 5'd2, 5'd0, 3'd2);
        wait_out(lat);
        chk("s_p1", InstructionP1, 12'b111111100000);
        chk("s_p2", InstructionP2, 5'b11101);
        chk("s_roundtrip", immgen(Instr), 64'hFFFF_FFFF_FFFF_FFFD);

        // Odd branch offset rejected, then the maximum branch offset accepted.
        send(5'b11000, 64'd5, 5'd0, 5'd1, 5'd2, 3'd0);
        expect_reject();
        chk("b_odd_err", err, 1);
        chk("b_odd_err_count", err_count, 1);
        send(5'b11000, 64'd4094, 5'd0, 5'd1, 5'd2, 3'd0);
        wait_out(lat);
        w0 = Instr;
        chk("b_max_bit31", w0[31], 0);
        chk("b_max_bit7", w0[7], 1);

        send(5'b01101, 64'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0);
        wait_out(lat);
        chk("u_instr", Instr, 32'h1234_52B7);
        send(5'b11011, -64'sd2, 5'd1, 5'd0, 5'd0, 3'd0);
        wait_out(lat);
        chk("j_instr", Instr, 32'hFFFF_F0EF);

        // Range boundaries that must pass.
        send(5'b00100, -64'sd2048, 5'd7, 5'd8, 5'd0, 3'd3); wait_out(lat);
        send(5'b11011, 64'd1048574, 5'd2, 5'd0, 5'd0, 3'd0); wait_out(lat);
        send(5'b11011, -64'sd1048576, 5'd3, 5'd0, 5'd0, 3'd0); wait_out(lat);
        send(5'b11000, -64'sd4096, 5'd0, 5'd9, 5'd10, 3'd1); wait_out(lat);
        send(5'b01000, 64'd2047, 5'd0, 5'd11, 5'd12, 3'd2); wait_out(lat);

        // Boundaries and formats that must fail.
        send(5'b00001, 64'd0, 5'd1, 5'd1, 5'd1, 3'd0);        expect_reject();
        send(5'b00100, 64'd2048, 5'd1, 5'd1, 5'd1, 3'd0);     expect_reject();
        send(5'b01101, 64'h0000_1001, 5'd1, 5'd0, 5'd0, 3'd0); expect_reject();
        send(5'b01101, 64'h8000_0000, 5'd1, 5'd0, 5'd0, 3'd0); expect_reject();
        send(5'b11011, 64'd1048576, 5'd1, 5'd0, 5'd0, 3'd0);  expect_reject();
        chk("fail_err_count", err_count, 6);

        // Back-pressure: word and address frozen, no new request taken.
        @(posedge clk); #1 out_ready = 1'b0;
        send(5'b00100, 64'd2047, 5'd3, 5'd4, 5'd0, 3'd1);
        wait_out(lat);
        w0 = Instr;
        a0 = wr_addr;
        @(posedge clk); #1;
        OpCode = 5'b00000; Imm = 64'd100; rd = 5'd6; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_instr", Instr, w0);
            chk("stall_addr", wr_addr, a0);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(5'b00000, 64'd100, 5'd6, 5'd0, 5'd0, 3'd0);
        wait_out(lat);
        chk("stall_next_latency", lat, 2);

        // Clear discards a pending word and restarts addressing.
        @(posedge clk); #1 out_ready = 1'b0;
        send(5'b00100, 64'd1, 5'd1, 5'd1, 5'd0, 3'd0);
        wait_out(lat);
        @(posedge clk); #1 clear = 1'b1;
        @(negedge clk);
        chk("clear_out_valid", out_valid, 0);
        @(posedge clk); #1 clear = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("clear_wr_addr", wr_addr, 0);
        chk("clear_err_count", err_count, 0);
        chk("clear_in_ready", in_ready, 1);

        // Reset in the middle of EMIT.
        send(5'b00010, 64'd0, 5'd0, 5'd0, 5'd0, 3'd0); expect_reject();
        @(posedge clk); #1 out_ready = 1'b0;
        send(5'b00100, 64'd12, 5'd1, 5'd2, 5'd0, 3'd0);
        wait_out(lat);
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("rst_mid_out_valid", out_valid, 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_err_count", err_count, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid_after", out_valid, 0);

        // Fill all 256 addresses.
        for (int i = 0; i < 256; i++) begin
            send(5'b00100, 64'(i), 5'(i), 5'd1, 5'd0, 3'd0);
            wait_out(lat);
        end
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_wr_addr", wr_addr, 255);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1 in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_still_blocked", in_ready, 0);
        @(posedge clk); #1 in_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("full_clear_wr_addr", wr_addr, 0);
        chk("full_clear_full", full, 0);
        chk("full_clear_in_ready", in_ready, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
